operand_sequencer: RTL



---
 rtl/lab_pkg.sv | 21 ++
 rtl/button_debouncer.sv | 60 ++++++
 rtl/operand_sequencer.sv | 91 +++++++++
 3 files changed

// File: rtl/lab_pkg.sv
// Shared definitions for the ZedBoard adder labs: operator FSM encodings,
// LED reset pattern and the LED word packing helper.
package lab_pkg;

  // FSM state codes double as the LED[7:6] display codes.
  localparam logic [1:0] ST_LOAD_A = 2'b01;
  localparam logic [1:0] ST_LOAD_B = 2'b10;
  localparam logic [1:0] ST_SHOW   = 2'b11;

  // LED pattern after reset: state LOAD_A, everything else dark.
  localparam logic [7:0] LED_RESET = 8'h40;

  // Pack the LED word: {state, debounced level, valid, nibble}.
  function automatic logic [7:0] led_word(input logic [1:0] st,
                                          input logic       level,
                                          input logic       valid,
                                          input logic [3:0] nibble);
    return {st, level, valid, nibble};
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Push-button front end: two-flop synchronizer, counter-based debouncer and
// a one-cycle pulse on every accepted rising level. Reused by later labs.
// DEBOUNCE_CYCLES must be 2 or more and 2**CNT_W >= DEBOUNCE_CYCLES.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  logic             sync1;
  logic             sync2;
  logic             deb;
  logic             deb_q;
  logic [CNT_W-1:0] cnt;

  // Bring the asynchronous button into the clock domain.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its source, giving a real two-stage chain.
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  // Accept a new level only after it has differed from deb for
  // DEBOUNCE_CYCLES consecutive cycles; any bounce back restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      deb <= 1'b0;
      cnt <= '0;
    end else if (sync2 == deb) begin
      cnt <= '0;
    end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      deb <= sync2;
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Delayed copy of deb for rising-edge detection.
  always_ff @(posedge clk) begin
    if (rst) deb_q <= 1'b0;
    else     deb_q <= deb;
  end

  assign level = deb;
  // One-cycle pulse on an accepted press; release produces nothing.
  assign press = deb & ~deb_q;

endmodule

// File: rtl/operand_sequencer.sv
// Operand entry front end for the 4-bit ripple-carry adder: the operator
// loads A then B from the switches with one debounced button, the adder sum
// is captured in SHOW, and the next press returns to LOAD_A.
module operand_sequencer
  import lab_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       BTN,
  input  logic [3:0] SWITCH,
  input  logic [3:0] SUM_IN,
  output logic [7:0] OPERANDS,
  output logic [7:0] LED
);

  logic       deb_level;
  logic       press;
  logic [1:0] state;
  logic [3:0] a;
  logic [3:0] b;
  logic [3:0] res;
  logic       valid;
  logic [7:0] led_r;

  button_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_debouncer (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (BTN),
    .level   (deb_level),
    .press   (press)
  );

  // Operator FSM and operand/result registers; every state consumes press,
  // so a one-cycle pulse is never lost or counted twice.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_LOAD_A;
      a     <= 4'h0;
      b     <= 4'h0;
      res   <= 4'h0;
      valid <= 1'b0;
    end else begin
      case (state)
        ST_LOAD_A: begin
          if (press) begin
            a     <= SWITCH;
            state <= ST_LOAD_B;
          end
        end
        ST_LOAD_B: begin
          if (press) begin
            b     <= SWITCH;
            valid <= 1'b0;
            state <= ST_SHOW;
          end
        end
        ST_SHOW: begin
          if (press) begin
            res   <= 4'h0;
            valid <= 1'b0;
            state <= ST_LOAD_A;
          end else if (!valid) begin
            // Operands have been stable since entering SHOW, so the adder
            // output is settled on this first edge.
            res   <= SUM_IN;
            valid <= 1'b1;
          end
        end
        default: state <= ST_LOAD_A;
      endcase
    end
  end

  // Registered LED word: state code, debounced level, valid, and either the
  // switch preview or the captured sum.
  always_ff @(posedge clk) begin
    if (rst) led_r <= LED_RESET;
    else     led_r <= led_word(state, deb_level, valid,
                               (state == ST_SHOW) ? res : SWITCH);
  end

  assign OPERANDS = {b, a};
  assign LED      = led_r;

endmodule
